fnd_source_scheduler: RTL

- Decides which data source owns the shared 4-digit FND path: the watch, the SR04 distance sensor or the DHT11 sensor.
- Sequences sources by button or by auto-rotation, and drives the two-page select (hour:min / sec:msec, or humidity / temperature).
- Latches sensor samples, flags stale data, and blanks the display briefly on every source change.
- Sits between the sensor/watch cores and the per-source FND controllers plus the final display mux.

---
 rtl/fnd_source_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fnd_source_scheduler.sv
// Chooses which source (watch, SR04, DHT11) owns the shared FND path, drives its
// page select, latches sensor samples, flags stale data and blanks on source change.
module fnd_source_scheduler #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int DWELL_MS = 3000,
  parameter int STALE_MS = 2000,
  parameter int BLANK_MS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_btn_next,
  input  logic        i_btn_page,
  input  logic        i_auto_en,
  input  logic [11:0] i_sr04_data,
  input  logic        i_sr04_valid,
  input  logic [31:0] i_dht_data,
  input  logic        i_dht_valid,
  output logic [1:0]  o_src_sel,
  output logic        o_sub_page,
  output logic        o_blank,
  output logic        o_stale,
  output logic [11:0] o_sr04_data,
  output logic [31:0] o_dht_data
);

  localparam int PRESC_DIV = CLK_FREQ / 1000;
  localparam int PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int CNT_MAX   = (DWELL_MS > STALE_MS) ? DWELL_MS : STALE_MS;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(PRESC_DIV - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_MS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_MS - 1);
  localparam logic [CW-1:0] STALE_LIM  = CW'(STALE_MS);

  typedef enum logic [1:0] {
    S_WATCH = 2'd0,
    S_SR04  = 2'd1,
    S_DHT   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q;
  logic [CW-1:0]   dwell_q;
  logic [CW-1:0]   blank_cnt_q;
  logic [CW-1:0]   sr_age_q, sr_age_d;
  logic [CW-1:0]   dht_age_q, dht_age_d;
  logic            tick;
  logic            adv;
  logic            stale_d;

  // Saturating age step: once a sensor is stale it stays pinned at the limit.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= STALE_LIM) return STALE_LIM;
    else                return v + 1'b1;
  endfunction

  function automatic logic [CW-1:0] age_next(input logic [CW-1:0] age,
                                             input logic          vld,
                                             input logic          tk);
    if (vld)     return '0;
    else if (tk) return sat_inc(age);
    else         return age;
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    adv     = i_btn_next | (i_auto_en & tick & (dwell_q == DWELL_LAST));
    state_d = state_q;
    if (adv) begin
      case (state_q)
        S_WATCH: state_d = S_SR04;
        S_SR04:  state_d = S_DHT;
        default: state_d = S_WATCH;
      endcase
    end
    sr_age_d  = age_next(sr_age_q, i_sr04_valid, tick);
    dht_age_d = age_next(dht_age_q, i_dht_valid, tick);
    // Stale is judged against the source and age that become visible next cycle.
    case (state_d)
      S_SR04:  stale_d = (sr_age_d >= STALE_LIM);
      S_DHT:   stale_d = (dht_age_d >= STALE_LIM);
      default: stale_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc_q <= '0;
    else if (tick) presc_q <= '0;
    else presc_q <= presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_WATCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q <= '0;
    end else if (adv || !i_auto_en) begin
      dwell_q <= '0;
    end else if (tick) begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  // Blanking restarts on every advance, even one that lands mid-blank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_blank     <= 1'b0;
      blank_cnt_q <= '0;
    end else if (adv) begin
      o_blank     <= 1'b1;
      blank_cnt_q <= '0;
    end else if (o_blank && tick) begin
      if (blank_cnt_q == BLANK_LAST) begin
        o_blank     <= 1'b0;
        blank_cnt_q <= '0;
      end else begin
        blank_cnt_q <= blank_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_sub_page <= 1'b0;
    end else if (adv) begin
      o_sub_page <= 1'b0;
    end else if (i_btn_page && (state_q != S_SR04)) begin
      o_sub_page <= ~o_sub_page;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_age_q  <= STALE_LIM;
      dht_age_q <= STALE_LIM;
      o_stale   <= 1'b0;
    end else begin
      sr_age_q  <= sr_age_d;
      dht_age_q <= dht_age_d;
      o_stale   <= stale_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_sr04_data <= '0;
      o_dht_data  <= '0;
    end else begin
      if (i_sr04_valid) o_sr04_data <= i_sr04_data;
      if (i_dht_valid)  o_dht_data  <= i_dht_data;
    end
  end

  assign o_src_sel = state_q;

endmodule
